// File: rtl/vip_rgb2yuv_if.sv
// Video bus between an RGB pixel source and the RGB->YCbCr converter.
// in_*  : line-valid, frame sync and RGB components toward the converter.
// out_* : delayed line-valid, frame sync and Y/Cb/Cr components from the converter.
// master : pixel source / consumer side (drives in_*, observes out_*).
// slave  : converter side (observes in_*, drives out_*).
interface vip_rgb2yuv_if #(
    parameter int BITS = 8
);
    logic            in_href;
    logic            in_vsync;
    logic [BITS-1:0] in_r;
    logic [BITS-1:0] in_g;
    logic [BITS-1:0] in_b;
    logic            out_href;
    logic            out_vsync;
    logic [BITS-1:0] out_y;
    logic [BITS-1:0] out_u;
    logic [BITS-1:0] out_v;

    modport master (
        output in_href, in_vsync, in_r, in_g, in_b,
        input  out_href, out_vsync, out_y, out_u, out_v
    );

    modport slave (
        input  in_href, in_vsync, in_r, in_g, in_b,
        output out_href, out_vsync, out_y, out_u, out_v
    );
endinterface

// File: rtl/vip_rgb2yuv.sv
// Pipelined RGB -> YCbCr (BT.601 limited range) converter.
// Stages: 1) nine coefficient products, 2) three signed sums with offset and
// rounding, 3) shift-by-9 and clamp. With YUV422=1 a fourth stage averages
// Cb/Cr over even/odd pixel pairs of a line. href/vsync are delayed by the
// same latency L (3 or 4) and Y/Cb/Cr are forced to 0 while out_href is low.
// Ports:
//   pclk  : pixel clock, rising edge
//   rst_n : asynchronous active-low reset
//   vid   : video bus (slave modport) carrying in_* pixels and out_* results
module vip_rgb2yuv #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int YUV422 = 0
) (
    input  logic         pclk,
    input  logic         rst_n,
    vip_rgb2yuv_if.slave vid
);
    localparam int L  = (YUV422 != 0) ? 4 : 3;
    localparam int PW = BITS + 9;
    localparam int SW = BITS + 12;
    // Offsets already include the +256 rounding term of the final >>9.
    localparam logic signed [SW-1:0] Y_OFF = SW'(((16 << (BITS - 8)) * 512) + 256);
    localparam logic signed [SW-1:0] C_OFF = SW'(((128 << (BITS - 8)) * 512) + 256);

    // Coefficient magnitudes, ordered Y(r,g,b), Cb(r,g,b), Cr(r,g,b).
    // Signs are applied in the sum stage so the products stay unsigned.
    function automatic logic [8:0] coef(input int idx);
        case (idx)
            0:       coef = 9'd132;
            1:       coef = 9'd258;
            2:       coef = 9'd50;
            3:       coef = 9'd76;
            4:       coef = 9'd149;
            5:       coef = 9'd225;
            6:       coef = 9'd225;
            7:       coef = 9'd188;
            8:       coef = 9'd36;
            default: coef = 9'd0;
        endcase
    endfunction

    function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
        ext = $signed({{(SW - PW){1'b0}}, p});
    endfunction

    function automatic logic [BITS-1:0] clamp(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = s >>> 9;
        if (t[SW-1])
            clamp = '0;
        else if (|t[SW-2:BITS])
            clamp = '1;
        else
            clamp = t[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] avg(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [BITS:0] s;
        s   = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, 1'b1};
        avg = BITS'(s >> 1);
    endfunction

    logic [BITS-1:0] comp [3];
    assign comp[0] = vid.in_r;
    assign comp[1] = vid.in_g;
    assign comp[2] = vid.in_b;

    // Stage 1: products
    logic [PW-1:0] prod_q [9];
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) prod_q[i] <= PW'(coef(i)) * PW'(comp[i % 3]);
        end
    end

    // Stage 2: signed sums
    logic signed [SW-1:0] sy_d, su_d, sv_d;
    logic signed [SW-1:0] sy_q, su_q, sv_q;
    always_comb begin
        sy_d = Y_OFF + ext(prod_q[0]) + ext(prod_q[1]) + ext(prod_q[2]);
        su_d = C_OFF - ext(prod_q[3]) - ext(prod_q[4]) + ext(prod_q[5]);
        sv_d = C_OFF + ext(prod_q[6]) - ext(prod_q[7]) - ext(prod_q[8]);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            sy_q <= '0;
            su_q <= '0;
            sv_q <= '0;
        end else begin
            sy_q <= sy_d;
            su_q <= su_d;
            sv_q <= sv_d;
        end
    end

    // Stage 3: shift and clamp. The clamped stage-2 chroma is also the
    // look-ahead partner for the pair averaging in 4:2:2 mode.
    logic [BITS-1:0] y_c, u_c, v_c;
    assign y_c = clamp(sy_q);
    assign u_c = clamp(su_q);
    assign v_c = clamp(sv_q);

    logic [BITS-1:0] y3_q, u3_q, v3_q;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            y3_q <= '0;
            u3_q <= '0;
            v3_q <= '0;
        end else begin
            y3_q <= y_c;
            u3_q <= u_c;
            v3_q <= v_c;
        end
    end

    // Sync delay lines; bit k marks the pixel currently in stage k+1.
    logic [L-1:0] hs_q, vs_q;
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            hs_q <= {hs_q[L-2:0], vid.in_href};
            vs_q <= {vs_q[L-2:0], vid.in_vsync};
        end
    end

    logic [BITS-1:0] y_f, u_f, v_f;

    if (YUV422 != 0) begin : g_422
        logic            phase_q, phase_d;
        logic [BITS-1:0] u_prev_q, v_prev_q;
        logic [BITS-1:0] y4_q, u4_q, v4_q;
        logic [BITS-1:0] u4_d, v4_d;

        // Phase of the pixel in stage 3; idle cycles restart at even.
        assign phase_d = hs_q[2] ? ~phase_q : 1'b0;

        always_comb begin
            u4_d = u3_q;
            v4_d = v3_q;
            if (phase_q) begin
                // Odd pixel: partner is the even pixel one cycle ahead.
                u4_d = avg(u_prev_q, u3_q);
                v4_d = avg(v_prev_q, v3_q);
            end else if (hs_q[1]) begin
                // Even pixel with a following pixel still in stage 2.
                u4_d = avg(u3_q, u_c);
                v4_d = avg(v3_q, v_c);
            end
        end

        always_ff @(posedge pclk or negedge rst_n) begin
            if (!rst_n) begin
                phase_q  <= 1'b0;
                u_prev_q <= '0;
                v_prev_q <= '0;
                y4_q     <= '0;
                u4_q     <= '0;
                v4_q     <= '0;
            end else begin
                phase_q  <= phase_d;
                u_prev_q <= u3_q;
                v_prev_q <= v3_q;
                y4_q     <= y3_q;
                u4_q     <= u4_d;
                v4_q     <= v4_d;
            end
        end

        assign y_f = y4_q;
        assign u_f = u4_q;
        assign v_f = v4_q;
    end else begin : g_444
        assign y_f = y3_q;
        assign u_f = u3_q;
        assign v_f = v3_q;
    end

    assign vid.out_href  = hs_q[L-1];
    assign vid.out_vsync = vs_q[L-1];
    assign vid.out_y     = hs_q[L-1] ? y_f : '0;
    assign vid.out_u     = hs_q[L-1] ? u_f : '0;
    assign vid.out_v     = hs_q[L-1] ? v_f : '0;
endmodule

// File: tb/tb_vip_rgb2yuv.sv
// Scoreboard bench for vip_rgb2yuv: one 4:4:4 and one 4:2:2 instance share
// the same stimulus. Expected pixels are queued as lines are issued; per-DUT
// monitors pop on out_href and check href/vsync delay and idle gating.
module tb_vip_rgb2yuv;
    localparam int BITS = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] u;
        logic [7:0] v;
    } yuv_t;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;
    always #5 pclk = ~pclk;

    vip_rgb2yuv_if #(.BITS(BITS)) if0 ();
    vip_rgb2yuv_if #(.BITS(BITS)) if1 ();

    vip_rgb2yuv #(.BITS(BITS), .WIDTH(8), .HEIGHT(4), .YUV422(0)) dut0 (
        .pclk (pclk),
        .rst_n(rst_n),
        .vid  (if0)
    );
    vip_rgb2yuv #(.BITS(BITS), .WIDTH(8), .HEIGHT(4), .YUV422(1)) dut1 (
        .pclk (pclk),
        .rst_n(rst_n),
        .vid  (if1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    yuv_t q0[$];
    yuv_t q1[$];
    logic [3:0] hh = '0;
    logic [3:0] hv = '0;

    logic [7:0] lr[16];
    logic [7:0] lg[16];
    logic [7:0] lb[16];
    yuv_t       le[16];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        if (x < 0) return 0;
        if (x > 255) return 255;
        return x;
    endfunction

    function automatic yuv_t conv(input int r, input int g, input int b);
        yuv_t o;
        o.y = 8'(sat((132 * r + 258 * g + 50 * b + 16 * 512 + 256) >>> 9));
        o.u = 8'(sat((-76 * r - 149 * g + 225 * b + 128 * 512 + 256) >>> 9));
        o.v = 8'(sat((225 * r - 188 * g - 36 * b + 128 * 512 + 256) >>> 9));
        return o;
    endfunction

    function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) >> 1;
        return 8'(s);
    endfunction

    task automatic load(input int i, input int r, input int g, input int b,
                        input int y, input int u, input int v);
        lr[i]   = 8'(r);
        lg[i]   = 8'(g);
        lb[i]   = 8'(b);
        le[i].y = 8'(y);
        le[i].u = 8'(u);
        le[i].v = 8'(v);
    endtask

    task automatic set_in(input logic h, input logic vs,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        if0.in_href = h; if0.in_vsync = vs; if0.in_r = r; if0.in_g = g; if0.in_b = b;
        if1.in_href = h; if1.in_vsync = vs; if1.in_r = r; if1.in_g = g; if1.in_b = b;
    endtask

    // Queue expectations for an n-pixel line, then drive the first 'stop'.
    task automatic drive_line(input int n, input int stop);
        yuv_t e;
        for (int i = 0; i < n; i++) begin
            q0.push_back(le[i]);
            e = le[i];
            if ((i % 2) == 0 && (i + 1) < n) begin
                e.u = avg2(le[i].u, le[i+1].u);
                e.v = avg2(le[i].v, le[i+1].v);
            end else if ((i % 2) == 1) begin
                e.u = avg2(le[i-1].u, le[i].u);
                e.v = avg2(le[i-1].v, le[i].v);
            end
            q1.push_back(e);
        end
        for (int i = 0; i < stop; i++) begin
            set_in(1'b1, 1'b0, lr[i], lg[i], lb[i]);
            @(posedge pclk); #1;
        end
        set_in(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic blank(input int k, input logic vs);
        set_in(1'b0, vs, 8'd0, 8'd0, 8'd0);
        repeat (k) begin
            @(posedge pclk); #1;
        end
        set_in(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    // Reference record of sampled syncs; bit k = value sampled k+1 edges ago.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hh <= '0;
            hv <= '0;
        end else begin
            hh <= {hh[2:0], if0.in_href};
            hv <= {hv[2:0], if0.in_vsync};
        end
    end

    always @(negedge pclk) begin : mon0
        yuv_t e;
        check("m444 href", int'(if0.out_href), int'(hh[2]));
        check("m444 vsync", int'(if0.out_vsync), int'(hv[2]));
        if (if0.out_href) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL m444 unexpected pixel: y=%0d u=%0d v=%0d, required none (t=%0t)",
                         if0.out_y, if0.out_u, if0.out_v, $time);
            end else begin
                e = q0.pop_front();
                check("m444 y", int'(if0.out_y), int'(e.y));
                check("m444 u", int'(if0.out_u), int'(e.u));
                check("m444 v", int'(if0.out_v), int'(e.v));
            end
        end else begin
            check("m444 idle yuv", int'({if0.out_y, if0.out_u, if0.out_v}), 0);
        end
    end

    always @(negedge pclk) begin : mon1
        yuv_t e;
        check("m422 href", int'(if1.out_href), int'(hh[3]));
        check("m422 vsync", int'(if1.out_vsync), int'(hv[3]));
        if (if1.out_href) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL m422 unexpected pixel: y=%0d u=%0d v=%0d, required none (t=%0t)",
                         if1.out_y, if1.out_u, if1.out_v, $time);
            end else begin
                e = q1.pop_front();
                check("m422 y", int'(if1.out_y), int'(e.y));
                check("m422 u", int'(if1.out_u), int'(e.u));
                check("m422 v", int'(if1.out_v), int'(e.v));
            end
        end else begin
            check("m422 idle yuv", int'({if1.out_y, if1.out_u, if1.out_v}), 0);
        end
    end

    initial begin
        int r, g, b;
        set_in(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;
        blank(2, 1'b0);

        // black, white, red, blue
        load(0,   0,   0,   0,  16, 128, 128);
        load(1, 255, 255, 255, 235, 128, 128);
        load(2, 255,   0,   0,  82,  90, 240);
        load(3,   0,   0, 255,  41, 240, 110);
        drive_line(4, 4);
        $display("line A issued: black white red blue");
        blank(1, 1'b0);

        // odd-length line: red, blue, red (third pixel unpaired)
        load(0, 255,   0,   0,  82,  90, 240);
        load(1,   0,   0, 255,  41, 240, 110);
        load(2, 255,   0,   0,  82,  90, 240);
        drive_line(3, 3);
        $display("line B issued: red blue red");
        blank(1, 1'b0);

        // next line must start at even phase after a 1-cycle gap
        load(0,   0, 255,   0, 144,  54,  34);
        load(1, 255, 255,   0, 210,  16, 146);
        load(2, 128, 128, 128, 126, 128, 128);
        load(3, 255, 255, 255, 235, 128, 128);
        load(4, 255,   0,   0,  82,  90, 240);
        drive_line(5, 5);
        $display("line C issued: green yellow gray white red");
        blank(6, 1'b0);

        // reset in the middle of an active line
        for (int i = 0; i < 6; i++) load(i, 0, 0, 255, 41, 240, 110);
        drive_line(6, 4);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("rst out_href 444", int'(if0.out_href), 0);
        check("rst out_vsync 444", int'(if0.out_vsync), 0);
        check("rst out_y 444", int'(if0.out_y), 0);
        check("rst out_href 422", int'(if1.out_href), 0);
        check("rst out_u 422", int'(if1.out_u), 0);
        $display("mid-line reset applied");
        @(posedge pclk); #1;
        rst_n = 1'b1;
        blank(1, 1'b0);

        load(0, 255, 255, 255, 235, 128, 128);
        load(1, 255,   0,   0,  82,  90, 240);
        drive_line(2, 2);
        $display("line D issued after reset: white red");
        blank(3, 1'b0);

        // random 8x4 frame against the integer model
        blank(2, 1'b1);
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < 8; i++) begin
                r = int'($urandom_range(0, 255));
                g = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                lr[i] = 8'(r);
                lg[i] = 8'(g);
                lb[i] = 8'(b);
                le[i] = conv(r, g, b);
            end
            drive_line(8, 8);
            $display("random line %0d issued", ln);
            blank(int'($urandom_range(1, 3)), 1'b0);
        end

        blank(8, 1'b0);
        check("q444 drained", q0.size(), 0);
        check("q422 drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vip_rgb2yuv.md
# vip_rgb2yuv

Pipelined RGB→YCbCr (BT.601, limited range) converter for the VIP video path. It is the inverse of the YUV→RGB stage and sits between the RGB/ISP output and the YUV encoder/SDRAM writer. The video timing on href/vsync is preserved. Optional 4:2:2 mode averages chroma over horizontal pixel pairs within each line.

## Interface
- BITS, 8: component width for all inputs and outputs.
- WIDTH, 1280: nominal line length. Informational only; not used for counting.
- HEIGHT, 960: nominal frame height. Informational only.
- YUV422, 0: 0 = 4:4:4 output; 1 = pair-averaged chroma (4:2:2 content, still one u/v per pixel).
- pclk  in  1  pixel clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_href  in  1  line-valid; one pixel per pclk while high.
- in_vsync  in  1  frame sync; delayed only, never interpreted.
- in_r, in_g, in_b  in  BITS each  pixel components, unsigned.
- out_href  out  1  in_href delayed by latency L.
- out_vsync  out  1  in_vsync delayed by latency L.
- out_y, out_u, out_v  out  BITS each  Y, Cb, Cr. Forced to 0 when out_href is 0.

## Operation
- Equations, scaled by 512:
  - Y·512 = 132R + 258G + 50B + (16<<(BITS-8))·512
  - Cb·512 = −76R − 149G + 225B + (128<<(BITS-8))·512
  - Cr·512 = 225R − 188G − 36B + (128<<(BITS-8))·512
- Arithmetic: unsigned products of width BITS+9. Sums are signed, width BITS+12.
- Rounding: add 256, then arithmetic shift right by 9.
- Saturation: clamp to [0, 2^BITS−1] (below 0 → 0, above max → all ones).
- Pipeline stage 1: register the 9 products.
- Pipeline stage 2: register the three signed sums, including offset and rounding constant.
- Pipeline stage 3: register the shift and clamp results.
- 4:2:2 mode (YUV422=1):
  - Pixel phase bit: cleared while the stage-3 href is low, toggles on each valid stage-3 pixel. First pixel of a line is even (phase 0).
  - An even pixel and the next odd pixel both output u = (Cb_even + Cb_odd + 1)>>1 and v = (Cr_even + Cr_odd + 1)>>1. Y is per pixel.
  - An even pixel with no partner (href falls after it, odd line length) outputs its own Cb/Cr.
  - One extra output register stage is added, so every pixel is delayed by 1 more cycle.
- Syncs: href/vsync delay shift registers of length L. Outputs are gated so out_y/u/v = 0 whenever out_href = 0.
- Reset: all pipeline registers, the phase bit, the sync delay lines and all outputs go to 0. Reset mid-line discards in-flight pixels. After release, the outputs stay 0 until valid pixels traverse the pipeline.

## Timing
- Latency L = 3 cycles (YUV422=0) or 4 cycles (YUV422=1), from input sample edge to output valid.
- Throughput: 1 pixel/cycle, no stalls, no backpressure.
- out_href/out_vsync edges are exactly in_href/in_vsync edges shifted by L.
- Blanking gaps of any length, including 1 cycle, between lines are supported. In 4:2:2 mode a 1-cycle href low restarts the phase at even.
- Outputs are registered, except for the href AND-gating.

## Test plan
- Reset then black (0,0,0) with href high → after 3 cycles, y=16, u=128, v=128. During reset and before latency, all outputs are 0.
- Pixel sequence white (255,255,255), red (255,0,0), blue (0,0,255) → (235,128,128), (82,90,240), (41,240,110) on consecutive cycles, with out_href aligned.
- YUV422=1, line of red then blue → both pixels u=165, v=175; y=82 then 41; latency 4.
- YUV422=1, 3-pixel line of red, blue, red → first pair averaged as above, third pixel (82,90,240). The next line starts at even phase.
- Assert rst_n low mid-line for 1 cycle → all outputs and out_href/out_vsync are 0 on the next edge. Clean conversion resumes L cycles after href is re-driven.
- Random RGB frames (8×4, 1–3 cycle blanking) vs. a golden integer model → bit-exact y/u/v, and exact href/vsync delay.
